// File: rtl/counter_1_12_monitor.sv
// Passive read-side checker for the MIN_VAL..MAX_VAL wrapping counter: predicts q each
// clock, compares, and reports mismatches as a pulse, sticky flag, counters and first-error capture.
module counter_1_12_monitor #(
  parameter int W       = 4,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 12,
  parameter int CW      = 16,
  parameter int RESYNC  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic [W-1:0]  d,
  input  logic [W-1:0]  q,
  output logic          armed,
  output logic          err,
  output logic          err_sticky,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] match_count,
  output logic [W-1:0]  first_exp,
  output logic [W-1:0]  first_got
);

  localparam logic [W-1:0]  MIN_V   = W'(MIN_VAL);
  localparam logic [W-1:0]  MAX_V   = W'(MAX_VAL);
  localparam logic [CW-1:0] CNT_TOP = '1;

  logic [W-1:0]  exp_q;
  logic          armed_q;
  logic          err_q;
  logic          sticky_q;
  logic [CW-1:0] err_cnt_q;
  logic [CW-1:0] match_cnt_q;
  logic [W-1:0]  first_exp_q;
  logic [W-1:0]  first_got_q;

  logic [W-1:0]  base;
  logic [W-1:0]  next_exp;
  logic          mismatch;

  // Values above MAX_VAL are not wrapped to MIN_VAL; they roll over modulo 2^W.
  always_comb begin
    base     = (RESYNC != 0) ? q : exp_q;
    next_exp = base;
    mismatch = (q != exp_q);
    if (load) begin
      next_exp = d;
    end else if (en) begin
      next_exp = (base == MAX_V) ? MIN_V : base + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q       <= MIN_V;
      armed_q     <= 1'b1;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      // The prediction keeps tracking even before the first reset arms the checker.
      exp_q <= next_exp;
      if (armed_q) begin
        if (mismatch) begin
          err_q    <= 1'b1;
          sticky_q <= 1'b1;
          if (err_cnt_q != CNT_TOP) begin
            err_cnt_q <= err_cnt_q + CW'(1);
          end
          if (!sticky_q) begin
            first_exp_q <= exp_q;
            first_got_q <= q;
          end
        end else begin
          err_q <= 1'b0;
          if (match_cnt_q != CNT_TOP) begin
            match_cnt_q <= match_cnt_q + CW'(1);
          end
        end
      end
    end
  end

  assign armed       = armed_q;
  assign err         = err_q;
  assign err_sticky  = sticky_q;
  assign err_count   = err_cnt_q;
  assign match_count = match_cnt_q;
  assign first_exp   = first_exp_q;
  assign first_got   = first_got_q;

endmodule

// File: tb/tb_counter_1_12_monitor.sv
// Bench for counter_1_12_monitor: three monitor instances (RESYNC=1, RESYNC=0, CW=4) watch a
// bench-driven counter that can be jammed or stuck to inject faults.
module tb_counter_1_12_monitor;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       load  = 1'b0;
  logic [3:0] d     = 4'd0;
  logic [3:0] ctr   = 4'd0;
  logic       jam   = 1'b0;
  logic [3:0] jam_val = 4'd0;
  logic       frc   = 1'b0;
  logic [3:0] frc_val = 4'd0;
  logic [3:0] q;

  // Counter under observation; jam makes it skip to jam_val, frc overrides its output.
  always @(posedge clk) begin
    if (reset)      ctr <= 4'd1;
    else if (jam)   ctr <= jam_val;
    else if (load)  ctr <= d;
    else if (en)    ctr <= (ctr == 4'd12) ? 4'd1 : ctr + 4'd1;
  end
  assign q = frc ? frc_val : ctr;

  // ---------------- DUTs ----------------
  logic        armed_o[3], err_o[3], sticky_o[3];
  logic [15:0] ec_o[3], mc_o[3];
  logic [3:0]  fe_o[3], fg_o[3];
  logic [3:0]  ec2, mc2;

  counter_1_12_monitor #(.RESYNC(1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .q(q),
    .armed(armed_o[0]), .err(err_o[0]), .err_sticky(sticky_o[0]),
    .err_count(ec_o[0]), .match_count(mc_o[0]), .first_exp(fe_o[0]), .first_got(fg_o[0]));

  counter_1_12_monitor #(.RESYNC(0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .q(q),
    .armed(armed_o[1]), .err(err_o[1]), .err_sticky(sticky_o[1]),
    .err_count(ec_o[1]), .match_count(mc_o[1]), .first_exp(fe_o[1]), .first_got(fg_o[1]));

  counter_1_12_monitor #(.CW(4), .RESYNC(1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .q(q),
    .armed(armed_o[2]), .err(err_o[2]), .err_sticky(sticky_o[2]),
    .err_count(ec2), .match_count(mc2), .first_exp(fe_o[2]), .first_got(fg_o[2]));
  assign ec_o[2] = {12'd0, ec2};
  assign mc_o[2] = {12'd0, mc2};

  // ---------------- behavioural model ----------------
  int rs[3]  = '{1, 0, 1};
  int top[3] = '{65535, 65535, 15};
  int m_armed[3] = '{0, 0, 0};
  int m_exp[3]   = '{0, 0, 0};
  int m_err[3]   = '{0, 0, 0};
  int m_st[3]    = '{0, 0, 0};
  int m_ec[3]    = '{0, 0, 0};
  int m_mc[3]    = '{0, 0, 0};
  int m_fe[3]    = '{0, 0, 0};
  int m_fg[3]    = '{0, 0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int qv, b;
      qv = int'(q);
      if (reset) begin
        m_exp[k] = 1; m_armed[k] = 1; m_err[k] = 0; m_st[k] = 0;
        m_ec[k] = 0; m_mc[k] = 0; m_fe[k] = 0; m_fg[k] = 0;
      end else begin
        if (m_armed[k] == 1) begin
          if (qv != m_exp[k]) begin
            m_err[k] = 1;
            if (m_ec[k] < top[k]) m_ec[k] = m_ec[k] + 1;
            if (m_st[k] == 0) begin m_fe[k] = m_exp[k]; m_fg[k] = qv; end
            m_st[k] = 1;
          end else begin
            m_err[k] = 0;
            if (m_mc[k] < top[k]) m_mc[k] = m_mc[k] + 1;
          end
        end
        b = (rs[k] == 1) ? qv : m_exp[k];
        if (load)        m_exp[k] = int'(d);
        else if (en)     m_exp[k] = (b == 12) ? 1 : (b + 1) % 16;
        else             m_exp[k] = b;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int k, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, k, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("armed", k, int'(armed_o[k]), m_armed[k]);
      chk("err", k, int'(err_o[k]), m_err[k]);
      chk("err_sticky", k, int'(sticky_o[k]), m_st[k]);
      chk("err_count", k, int'(ec_o[k]), m_ec[k]);
      chk("match_count", k, int'(mc_o[k]), m_mc[k]);
      chk("first_exp", k, int'(fe_o[k]), m_fe[k]);
      chk("first_got", k, int'(fg_o[k]), m_fg[k]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_q(input logic [3:0] v);
    int found;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (q == v) found = 1;
      else tick(1);
    end
    chk("wait_q_timeout", int'(v), found, 1);
  endtask

  // ---------------- directed sequence ----------------
  int ec_snap;
  initial begin
    // No reset yet: the checker stays unarmed and counts nothing.
    en = 1'b1;
    tick(5);
    chk("pre_reset_armed", 0, int'(armed_o[0]), 0);
    chk("pre_reset_err_count", 0, int'(ec_o[0]), 0);
    chk("pre_reset_match_count", 0, int'(mc_o[0]), 0);

    // Healthy counting through a full wrap.
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("post_reset_armed", 0, int'(armed_o[0]), 1);
    chk("post_reset_match", 0, int'(mc_o[0]), 0);
    tick(15);
    chk("t1_match_count", 0, int'(mc_o[0]), 15);
    chk("t1_err_count", 0, int'(ec_o[0]), 0);
    chk("t1_q_after", 0, int'(q), 4);

    // Load has the final say: 3 -> 9 -> 10 -> 11 -> 12 -> 1.
    wait_q(4'd3);
    load = 1'b1; d = 4'd9; tick(1); load = 1'b0;
    chk("t2_q9", 0, int'(q), 9);   tick(1);
    chk("t2_q10", 0, int'(q), 10); tick(1);
    chk("t2_q11", 0, int'(q), 11); tick(1);
    chk("t2_q12", 0, int'(q), 12); tick(1);
    chk("t2_q1", 0, int'(q), 1);
    chk("t2_err_count", 0, int'(ec_o[0]), 0);

    // Counter skips 4: q shows 5 while 4 is expected.
    wait_q(4'd3);
    jam = 1'b1; jam_val = 4'd5; tick(1); jam = 1'b0;
    tick(1);
    chk("t3_err_pulse", 0, int'(err_o[0]), 1);
    chk("t3_err_count", 0, int'(ec_o[0]), 1);
    chk("t3_first_exp", 0, int'(fe_o[0]), 4);
    chk("t3_first_got", 0, int'(fg_o[0]), 5);
    chk("t3_sticky", 0, int'(sticky_o[0]), 1);
    tick(1);
    chk("t3_err_cleared", 0, int'(err_o[0]), 0);
    chk("t3_err_count_hold", 0, int'(ec_o[0]), 1);
    chk("t4_err_again", 1, int'(err_o[1]), 1);
    chk("t4_err_count", 1, int'(ec_o[1]), 2);
    chk("t4_first_exp", 1, int'(fe_o[1]), 4);
    chk("t4_first_got", 1, int'(fg_o[1]), 5);

    // Realign the free-running prediction with a load.
    tick(3);
    load = 1'b1; d = 4'd2; tick(1); load = 1'b0;
    tick(1);
    ec_snap = int'(ec_o[1]);
    tick(3);
    chk("t4_realigned_err", 1, int'(err_o[1]), 0);
    chk("t4_realigned_count", 1, int'(ec_o[1]), ec_snap);
    chk("t4_first_exp_kept", 1, int'(fe_o[1]), 4);

    // Stuck output: saturation of the narrow counter.
    reset = 1'b1; tick(1); reset = 1'b0;
    frc = 1'b1; frc_val = 4'd7;
    tick(20);
    chk("t5_cw4_saturated", 2, int'(ec_o[2]), 15);
    chk("t5_cw4_match_le1", 2, int'(mc_o[2] <= 16'd1), 1);
    chk("t5_err_count", 0, int'(ec_o[0]), 20);
    chk("t5_first_exp", 0, int'(fe_o[0]), 1);
    chk("t5_first_got", 0, int'(fg_o[0]), 7);

    // Reset mid-run clears everything; next compare expects 1.
    reset = 1'b1; tick(1); reset = 1'b0;
    frc = 1'b0;
    chk("t6_sticky_cleared", 0, int'(sticky_o[0]), 0);
    chk("t6_err_count_cleared", 0, int'(ec_o[0]), 0);
    chk("t6_match_cleared", 0, int'(mc_o[0]), 0);
    chk("t6_cw4_cleared", 2, int'(ec_o[2]), 0);
    tick(1);
    chk("t6_first_match", 0, int'(mc_o[0]), 1);
    chk("t6_no_err", 0, int'(err_o[0]), 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
